// File: rtl/multdiv_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : multdiv_pkg                                                  |
// | Description : Shared types and constants for the multiply/divide unit.     |
// |               MULTDIV_BOOTH_EN selects the 16-step Booth multiply count.   |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
package multdiv_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    typedef enum logic {
        OP_MUL = 1'b0,
        OP_DIV = 1'b1
    } op_t;

`ifdef MULTDIV_BOOTH_EN
    localparam int ITER_MUL = 16;
`else
    localparam int ITER_MUL = 32;
`endif
    localparam int          ITER_DIV = 32;
    localparam int          CNT_W    = 6;
    localparam logic [31:0] INT_MIN  = 32'h8000_0000;

    function automatic logic [31:0] mag32(input logic [31:0] v);
        return v[31] ? (~v + 32'd1) : v;
    endfunction

endpackage
`default_nettype wire

// File: rtl/md_step_counter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : md_step_counter                                              |
// | Description : Loadable down counter; o_last flags the final iteration.     |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module md_step_counter
    import multdiv_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             i_load,
    input  logic [CNT_W-1:0] i_load_value,
    input  logic             i_en,
    output logic             o_last
);

    logic [CNT_W-1:0] r_count;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_value;
        end else if (i_en && (r_count != '0)) begin
            r_count <= r_count - 1'b1;
        end
    end

    assign o_last = (r_count == '0);

endmodule
`default_nettype wire

// File: rtl/multdiv_seq.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : multdiv_seq                                                  |
// | Description : Iterative signed 32-bit multiply/divide with tagged result.  |
// |               MULTDIV_BOOTH_EN selects a radix-4 Booth multiply.           |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module multdiv_seq
    import multdiv_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int TAG_W = 5
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] data_operandA,
    input  logic [WIDTH-1:0] data_operandB,
    input  logic             ctrl_MULT,
    input  logic             ctrl_DIV,
    input  logic [TAG_W-1:0] in_rd,
    output logic [WIDTH-1:0] data_result,
    output logic             data_exception,
    output logic             data_resultRDY,
    output logic [TAG_W-1:0] out_rd,
    output logic             busy
);

    localparam logic [CNT_W-1:0] c_load_mul = CNT_W'(ITER_MUL - 1);
    localparam logic [CNT_W-1:0] c_load_div = CNT_W'(ITER_DIV - 1);

    state_t           r_state, w_state_next;
    op_t              r_op, w_start_op;
    logic             w_start, w_run, w_last;
    logic [CNT_W-1:0] w_load_value;

    logic [63:0]      r_acc;
    logic [31:0]      r_b;
    logic             r_neg, r_div_zero, r_div_ovf;
    logic [TAG_W-1:0] r_tag;

    logic [31:0]      r_result;
    logic             r_exc, r_rdy;
    logic [TAG_W-1:0] r_out_rd;

    logic [63:0]      w_mul_next, w_prod;
    logic [32:0]      w_div_diff;
    logic [63:0]      w_div_next;
    logic [31:0]      w_quot, w_result;
    logic             w_exc;

    assign w_start      = (r_state == IDLE) && (ctrl_MULT || ctrl_DIV);
    assign w_start_op   = ctrl_MULT ? OP_MUL : OP_DIV;
    assign w_load_value = (w_start_op == OP_MUL) ? c_load_mul : c_load_div;
    assign w_run        = (r_state == RUN);

    md_step_counter u_step_counter (
        .clk          (clock),
        .rst          (reset),
        .i_load       (w_start),
        .i_load_value (w_load_value),
        .i_en         (w_run),
        .o_last       (w_last)
    );

    always_ff @(posedge clock) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (w_start) w_state_next = RUN;
            RUN:     if (w_last) w_state_next = DONE;
            DONE:    w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    // Restoring divide: remainder in r_acc[63:32], dividend/quotient in r_acc[31:0].
    // The remainder stays below the divisor, so r_acc[63] is always zero here.
    assign w_div_diff = {1'b0, r_acc[62:31]} - {1'b0, r_b};
    assign w_div_next = w_div_diff[32] ? {r_acc[62:0], 1'b0}
                                       : {w_div_diff[31:0], r_acc[30:0], 1'b1};
    assign w_quot     = r_neg ? (~r_acc[31:0] + 32'd1) : r_acc[31:0];

`ifdef MULTDIV_BOOTH_EN
    logic [63:0] r_mc;
    logic [32:0] r_mq;
    logic [63:0] w_pp;

    always_comb begin
        case (r_mq[2:0])
            3'b001, 3'b010: w_pp = r_mc;
            3'b011:         w_pp = r_mc << 1;
            3'b100:         w_pp = -(r_mc << 1);
            3'b101, 3'b110: w_pp = -r_mc;
            default:        w_pp = '0;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_mc <= '0;
            r_mq <= '0;
        end else if (w_start) begin
            r_mc <= {{32{data_operandA[31]}}, data_operandA};
            r_mq <= {data_operandB, 1'b0};
        end else if (w_run) begin
            r_mc <= r_mc << 2;
            r_mq <= {r_mq[32], r_mq[32], r_mq[32:2]};
        end
    end

    // Booth works on signed operands, so the accumulator is already the product.
    assign w_mul_next = r_acc + w_pp;
    assign w_prod     = r_acc;
`else
    logic [32:0] w_mul_sum;

    // Multiplier magnitude shifts out of r_acc[31:0] as the product shifts in.
    assign w_mul_sum  = {1'b0, r_acc[63:32]} + (r_acc[0] ? {1'b0, r_b} : 33'd0);
    assign w_mul_next = {w_mul_sum, r_acc[31:1]};
    assign w_prod     = r_neg ? (~r_acc + 64'd1) : r_acc;
`endif

    always_comb begin
        w_result = '0;
        w_exc    = 1'b0;
        if (r_op == OP_MUL) begin
            w_result = w_prod[31:0];
            w_exc    = (w_prod[63:32] != {32{w_prod[31]}});
        end else if (r_div_zero) begin
            w_exc    = 1'b1;
        end else if (r_div_ovf) begin
            w_result = INT_MIN;
            w_exc    = 1'b1;
        end else begin
            w_result = w_quot;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_op       <= OP_MUL;
            r_acc      <= '0;
            r_b        <= '0;
            r_neg      <= 1'b0;
            r_div_zero <= 1'b0;
            r_div_ovf  <= 1'b0;
            r_tag      <= '0;
            r_result   <= '0;
            r_exc      <= 1'b0;
            r_rdy      <= 1'b0;
            r_out_rd   <= '0;
        end else begin
            r_rdy <= 1'b0;
            case (r_state)
                IDLE: if (w_start) begin
                    r_op       <= w_start_op;
                    r_tag      <= in_rd;
                    r_neg      <= data_operandA[31] ^ data_operandB[31];
                    r_div_zero <= (data_operandB == '0);
                    r_div_ovf  <= (data_operandA == INT_MIN) && (data_operandB == '1);
`ifdef MULTDIV_BOOTH_EN
                    r_acc      <= (w_start_op == OP_MUL) ? 64'd0
                                                         : {32'd0, mag32(data_operandA)};
                    r_b        <= mag32(data_operandB);
`else
                    r_acc      <= {32'd0, (w_start_op == OP_MUL) ? mag32(data_operandB)
                                                                 : mag32(data_operandA)};
                    r_b        <= (w_start_op == OP_MUL) ? mag32(data_operandA)
                                                         : mag32(data_operandB);
`endif
                end
                RUN:  r_acc <= (r_op == OP_MUL) ? w_mul_next : w_div_next;
                DONE: begin
                    r_result <= w_result;
                    r_exc    <= w_exc;
                    r_out_rd <= r_tag;
                    r_rdy    <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign data_result    = r_result;
    assign data_exception = r_exc;
    assign data_resultRDY = r_rdy;
    assign out_rd         = r_out_rd;
    assign busy           = (r_state != IDLE) || r_rdy;

endmodule
`default_nettype wire
